// File: rtl/iter_shift_unit_if.sv
// Request/response handshake bundle for iter_shift_unit.
// The shift kind is called "op" because "type" is a reserved word.
interface iter_shift_unit_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shamt;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, a, shamt, op, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, a, shamt, op, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter (SRL/SLL/SRA, op 11) moving STEP bits per cycle.
// Optional macro ITER_SHIFT_ROTATE_EN: op 11 rotates right; otherwise op 11 passes a through.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic clk,
  input logic rst,
  iter_shift_unit_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] STEP_W  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_W = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_d;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   rem_d;
  logic [SHW:0]     k;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] outData_q;
  logic             outValid_q;
  logic             skipShift;

  // One step of the latched operation by k = min(STEP, rem).
  always_comb begin
    k = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
    rem_d = rem_q - k[SHW-1:0];
    case (op_q)
      2'b00:   work_d = work_q >> k;
      2'b01:   work_d = work_q << k;
      2'b10:   work_d = $unsigned($signed(work_q) >>> k);
`ifdef ITER_SHIFT_ROTATE_EN
      default: work_d = (work_q >> k) | (work_q << (WIDTH_W - k));
`else
      default: work_d = work_q;
`endif
    endcase
  end

`ifdef ITER_SHIFT_ROTATE_EN
  assign skipShift = (bus.shamt == '0);
`else
  assign skipShift = (bus.shamt == '0) || (bus.op == 2'b11);
`endif

  // DONE spends its first cycle registering the result, then holds it until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      rem_q      <= '0;
      op_q       <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q <= bus.a;
            op_q   <= bus.op;
            if (skipShift) begin
              rem_q   <= '0;
              state_q <= DONE;
            end else begin
              rem_q   <= bus.shamt;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (rem_d == '0) state_q <= DONE;
        end
        DONE: begin
          if (!outValid_q) begin
            outValid_q <= 1'b1;
            outData_q  <= work_q;
          end else if (bus.out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = outValid_q;
  assign bus.out       = outData_q;
endmodule

// File: tb/tb_iter_shift_unit.sv
// Scoreboard bench for iter_shift_unit: whole-word reference shifts, decoupled monitor.
module tb_iter_shift_unit;
  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acceptCycle;
  } exp_t;

  logic clk;
  logic rst;
  int   cycleCount;
  int   checks;
  int   fails;
  bit   randReady;
  bit   forcedReady;
  bit   prevValid;
  exp_t expQ[$];

  iter_shift_unit_if #(.WIDTH(WIDTH)) bus ();

  iter_shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Whole-word shift in one go, independent of how the hardware steps.
  function automatic logic [31:0] refShift(logic [31:0] a, int s, logic [1:0] op);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      2'b00: return a >> s;
      2'b01: return a << s;
      2'b10: return sa >>> s;
      default: begin
`ifdef ITER_SHIFT_ROTATE_EN
        if (s == 0) return a;
        return (a >> s) | (a << (32 - s));
`else
        return a;
`endif
      end
    endcase
  endfunction

  function automatic int refLatency(int s, logic [1:0] op);
`ifndef ITER_SHIFT_ROTATE_EN
    if (op == 2'b11) return 1;
`endif
    return 1 + (s + STEP - 1) / STEP;
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(logic [31:0] a, int s, logic [1:0] op);
    exp_t e;
    bit   done;
    done = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.shamt    = 5'(s);
    bus.op       = op;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.data        = refShift(a, s, op);
        e.lat         = refLatency(s, op);
        e.acceptCycle = cycleCount + 1;
        expQ.push_back(e);
        done = 1;
      end
    end
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.shamt    = 5'($urandom);
    bus.op       = 2'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
  endtask

  // Consumer side: random or forced back-pressure, changed just after the edge.
  always @(posedge clk) begin
    #1;
    bus.out_ready = randReady ? 1'($urandom_range(0, 1)) : forcedReady;
  end

  // Monitor: latency on each new result, data while held and when taken.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", bus.out, 32'hxxxx_xxxx);
        end else begin
          if (!prevValid)
            checkOutput("latency", 32'(cycleCount - expQ[0].acceptCycle), 32'(expQ[0].lat));
          if (bus.out_ready) begin
            checkOutput("result", bus.out, expQ[0].data);
            void'(expQ.pop_front());
          end else begin
            checkOutput("result_hold", bus.out, expQ[0].data);
          end
        end
      end
      prevValid = bus.out_valid;
    end
  end

  initial begin
    cycleCount    = 0;
    checks        = 0;
    fails         = 0;
    randReady     = 1'b0;
    forcedReady   = 1'b1;
    prevValid     = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.shamt     = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_out", bus.out, 32'd0);
    rst = 1'b0;

    applyStimulus(32'h8000_0000, 31, 2'b00);
    drain();
    applyStimulus(32'hF000_0000, 5, 2'b10);
    drain();
    applyStimulus(32'h0000_0001, 0, 2'b01);
    drain();
    applyStimulus(32'h0000_0001, 1, 2'b11);
    drain();
    applyStimulus(32'hFFFF_FFFF, 31, 2'b01);
    drain();

    // Back-pressure: result held, requests ignored while the unit is occupied.
    forcedReady = 1'b0;
    applyStimulus(32'h0000_0001, 3, 2'b01);
    bus.in_valid = 1'b1;
    bus.a        = 32'hDEAD_BEEF;
    bus.shamt    = 5'd7;
    bus.op       = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("busy_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    forcedReady  = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    checkOutput("no_extra_result", 32'(expQ.size()), 32'd0);

    // Reset during the second SHIFT cycle discards the work.
    applyStimulus(32'hA5A5_A5A5, 20, 2'b00);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    expQ.delete();
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midreset_out", bus.out, 32'd0);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom, int'($urandom_range(0, WIDTH - 1)), 2'($urandom_range(0, 3)));
    end
    applyStimulus(32'h8765_4321, 31, 2'b10);
    applyStimulus(32'h1234_5678, 31, 2'b11);
    drain();
    randReady = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
